// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared FU/CDB definitions for the CDB broadcast path
package sys_defs;

  localparam int FU_SIZE = 20;
  localparam int XLEN    = 32;
  localparam int PRF_W   = 6;
  localparam int ROB_W   = 5;
  localparam int FU_W    = 5;

  localparam int ALU_OFFSET  = 0;
  localparam int LS_OFFSET   = 8;
  localparam int MULT_OFFSET = 12;
  localparam int BEQ_OFFSET  = 16;

  // Lane 0 owns {0,2,4,6,9,11,12,14,17,19}; lane 1 owns the rest.
  localparam logic [FU_SIZE-1:0] LANE0_MASK = 20'hA5A55;
  localparam logic [FU_SIZE-1:0] LANE1_MASK = 20'h5A5AA;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  value;
    logic [PRF_W-1:0] tag;
    logic [ROB_W-1:0] rob;
  } cdb_packet_t;

  function automatic logic fu_in_range(input logic [FU_W-1:0] n);
    return n < FU_W'(FU_SIZE);
  endfunction

endpackage

// File: rtl/cdb_lane.sv
// rtl/cdb_lane.sv - one CDB lane: pick qualification, result mux, payload register, ack decode
module cdb_lane
  import sys_defs::*;
#(
  parameter logic [FU_SIZE-1:0] LANE_MASK = LANE0_MASK
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [FU_SIZE-1:0]       fu_result_valid_i,
  input  logic [FU_SIZE*XLEN-1:0]  fu_result_value_i,
  input  logic [FU_SIZE*PRF_W-1:0] fu_result_tag_i,
  input  logic [FU_SIZE*ROB_W-1:0] fu_result_rob_i,
  input  logic [FU_W-1:0]          fu_num_i,
  input  logic [FU_W-1:0]          fu_num_other_i,
  input  logic                     adv_i,
  input  logic                     squash_i,
  output logic                     sel_o,
  output logic                     err_o,
  output logic [FU_SIZE-1:0]       ack_o,
  output cdb_packet_t              pkt_o
);

  cdb_packet_t    pkt_q, pkt_d;
  logic [FU_W-1:0] idx;
  logic            in_range, req, in_set, conflict;

  always_comb begin
    in_range = fu_in_range(fu_num_i);
    idx      = in_range ? fu_num_i : '0;
    req      = in_range && fu_result_valid_i[idx];
    in_set   = in_range && LANE_MASK[idx];
    conflict = (fu_num_i == fu_num_other_i);
    sel_o    = req && in_set && !conflict;
    // A raised valid on a pick this lane must not take is a selector bug.
    err_o    = req && !(in_set && !conflict);
    ack_o    = '0;
    if (adv_i && sel_o) ack_o[idx] = 1'b1;

    pkt_d = pkt_q;
    if (squash_i) begin
      pkt_d.valid = 1'b0;
    end else if (adv_i) begin
      pkt_d.valid = sel_o;
      if (sel_o) begin
        pkt_d.value = fu_result_value_i[idx*XLEN +: XLEN];
        pkt_d.tag   = fu_result_tag_i[idx*PRF_W +: PRF_W];
        pkt_d.rob   = fu_result_rob_i[idx*ROB_W +: ROB_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) pkt_q <= '0;
    else        pkt_q <= pkt_d;
  end

  assign pkt_o = pkt_q;

endmodule

// File: rtl/cdb_broadcast_2.sv
// rtl/cdb_broadcast_2.sv - two-lane CDB broadcast with back-pressure, squash, counter and error flag
module cdb_broadcast_2
  import sys_defs::*;
#(
  parameter int PERF_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [FU_SIZE-1:0]       fu_result_valid,
  input  logic [FU_SIZE*XLEN-1:0]  fu_result_value,
  input  logic [FU_SIZE*PRF_W-1:0] fu_result_tag,
  input  logic [FU_SIZE*ROB_W-1:0] fu_result_rob,
  input  logic [FU_W-1:0]          fu_num_0,
  input  logic [FU_W-1:0]          fu_num_1,
  input  logic                     cdb_ready,
  input  logic                     squash,
  output logic [FU_SIZE-1:0]       fu_result_ack,
  output logic                     cdb_valid_0,
  output logic                     cdb_valid_1,
  output logic [XLEN-1:0]          cdb_value_0,
  output logic [XLEN-1:0]          cdb_value_1,
  output logic [PRF_W-1:0]         cdb_tag_0,
  output logic [PRF_W-1:0]         cdb_tag_1,
  output logic [ROB_W-1:0]         cdb_rob_0,
  output logic [ROB_W-1:0]         cdb_rob_1,
  output logic [PERF_W-1:0]        perf_bcast_cnt,
  output logic                     proto_err
);

  logic               adv, sel_0, sel_1, err_0, err_1;
  logic [FU_SIZE-1:0] ack_0, ack_1;
  cdb_packet_t        pkt_0, pkt_1;
  logic [PERF_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W:0]    cnt_sum;
  logic               proto_err_q, proto_err_d;

  assign adv = cdb_ready && !squash;

  cdb_lane #(.LANE_MASK(LANE0_MASK)) u_lane_0 (
    .clock(clock), .reset(reset),
    .fu_result_valid_i(fu_result_valid), .fu_result_value_i(fu_result_value),
    .fu_result_tag_i(fu_result_tag), .fu_result_rob_i(fu_result_rob),
    .fu_num_i(fu_num_0), .fu_num_other_i(fu_num_1),
    .adv_i(adv), .squash_i(squash),
    .sel_o(sel_0), .err_o(err_0), .ack_o(ack_0), .pkt_o(pkt_0)
  );

  cdb_lane #(.LANE_MASK(LANE1_MASK)) u_lane_1 (
    .clock(clock), .reset(reset),
    .fu_result_valid_i(fu_result_valid), .fu_result_value_i(fu_result_value),
    .fu_result_tag_i(fu_result_tag), .fu_result_rob_i(fu_result_rob),
    .fu_num_i(fu_num_1), .fu_num_other_i(fu_num_0),
    .adv_i(adv), .squash_i(squash),
    .sel_o(sel_1), .err_o(err_1), .ack_o(ack_1), .pkt_o(pkt_1)
  );

  // FUs must not drop their results while the block is held in reset.
  assign fu_result_ack = reset ? (ack_0 | ack_1) : '0;

  always_comb begin
    cnt_sum     = {1'b0, cnt_q} + (PERF_W+1)'(sel_0) + (PERF_W+1)'(sel_1);
    cnt_d       = cnt_q;
    if (adv) cnt_d = cnt_sum[PERF_W] ? '1 : cnt_sum[PERF_W-1:0];
    proto_err_d = proto_err_q | err_0 | err_1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign cdb_valid_0    = pkt_0.valid;
  assign cdb_value_0    = pkt_0.value;
  assign cdb_tag_0      = pkt_0.tag;
  assign cdb_rob_0      = pkt_0.rob;
  assign cdb_valid_1    = pkt_1.valid;
  assign cdb_value_1    = pkt_1.value;
  assign cdb_tag_1      = pkt_1.tag;
  assign cdb_rob_1      = pkt_1.rob;
  assign perf_bcast_cnt = cnt_q;
  assign proto_err      = proto_err_q;

endmodule
